// File: rtl/default_regfile_pkg.sv
// default_regfile_pkg
//   Shared types and helpers for the default-value register file.
//   - state_e    : restore-sweep FSM states.
//   - default_of : extracts channel k's default from a packed default vector.
//   - even_par   : even-parity bit of a data word.
//   Optional parity storage in the top is enabled by DEFAULT_REGFILE_PARITY_EN.
package default_regfile_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SWEEP,
      DONE
   } state_e;

   // Upper bounds: 64 channels x 64 bits.
   localparam int MAX_W    = 64;
   localparam int MAX_BITS = 4096;

   function automatic logic [MAX_W-1:0] default_of(input logic [MAX_BITS-1:0] vals,
                                                   input int k,
                                                   input int width);
      logic [MAX_BITS-1:0] shifted;
      logic [MAX_W-1:0]    mask;
      shifted = vals >> (k * width);
      mask    = (width >= MAX_W) ? '1 : ((64'd1 << width) - 64'd1);
      return shifted[MAX_W-1:0] & mask;
   endfunction

   // Parity bit that makes the total count of ones (data + bit) even.
   function automatic logic even_par(input logic [MAX_W-1:0] data);
      return ^data;
   endfunction

endpackage

// File: rtl/default_regfile_sweep.sv
// default_regfile_sweep
//   Restore-to-default sequencer: IDLE -> SWEEP (NUM_CH cycles) -> DONE -> IDLE.
//   Ports:
//     i_clk, i_rst_n   : clock, asynchronous active-low reset
//     i_restore        : level-sampled start request, honoured only in IDLE
//     o_idle           : state is IDLE (drives write-ready in the top)
//     o_busy           : sweep in progress
//     o_restore_done   : one-cycle pulse after the last channel is restored
//     o_sweep_en       : top must load channel o_sweep_idx with its default
//     o_sweep_idx      : channel being restored this cycle
module default_regfile_sweep
   import default_regfile_pkg::*;
#(
   parameter int NUM_CH = 4,
   parameter int CH_W   = 2
) (
   input  logic            i_clk,
   input  logic            i_rst_n,
   input  logic            i_restore,
   output logic            o_idle,
   output logic            o_busy,
   output logic            o_restore_done,
   output logic            o_sweep_en,
   output logic [CH_W-1:0] o_sweep_idx
);

   localparam logic [CH_W-1:0] LAST = CH_W'(NUM_CH - 1);

   state_e          state;
   logic [CH_W-1:0] idx;
   logic            busy;
   logic            done;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state <= IDLE;
         idx   <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (i_restore) begin
                  state <= SWEEP;
                  idx   <= '0;
                  busy  <= 1'b1;
               end
            end
            SWEEP: begin
               // Restore requests arriving here are dropped, not queued.
               if (idx == LAST) begin
                  state <= DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end else begin
                  idx <= idx + CH_W'(1);
               end
            end
            DONE: begin
               done  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

   assign o_idle         = (state == IDLE);
   assign o_busy         = busy;
   assign o_restore_done = done;
   assign o_sweep_en     = busy;
   assign o_sweep_idx    = idx;

endmodule

// File: rtl/default_value_regfile.sv
// default_value_regfile
//   Bank of NUM_CH registers of WIDTH bits, each returning to its own default
//   (DEFAULT_VAL[k*WIDTH +: WIDTH]) on reset or via a multi-cycle restore sweep.
//   Ports:
//     i_clk, i_rst_n                     : clock, asynchronous active-low reset
//     i_wr_valid/o_wr_ready/i_wr_ch/i_wr_data : write handshake (ready only in IDLE)
//     o_wr_err                           : pulse after an accepted out-of-range write
//     i_restore/o_busy/o_restore_done    : restore sweep control and status
//     i_rd_en/i_rd_ch/o_rd_valid/o_rd_data : registered read, one-cycle latency
//     o_values                           : live flat view of all channels
//   Optional (`define DEFAULT_REGFILE_PARITY_EN):
//     i_par_flip   : invert stored parity on an accepted write
//     o_rd_par_err : stored parity mismatch on the read channel
module default_value_regfile
   import default_regfile_pkg::*;
#(
   parameter int                      NUM_CH      = 4,
   parameter int                      WIDTH       = 8,
   parameter logic [NUM_CH*WIDTH-1:0] DEFAULT_VAL = '0,
   parameter int                      CH_W        = $clog2((NUM_CH > 1) ? NUM_CH : 2)
) (
   input  logic                    i_clk,
   input  logic                    i_rst_n,
`ifdef DEFAULT_REGFILE_PARITY_EN
   input  logic                    i_par_flip,
   output logic                    o_rd_par_err,
`endif
   input  logic                    i_wr_valid,
   output logic                    o_wr_ready,
   input  logic [CH_W-1:0]         i_wr_ch,
   input  logic [WIDTH-1:0]        i_wr_data,
   output logic                    o_wr_err,
   input  logic                    i_restore,
   output logic                    o_busy,
   output logic                    o_restore_done,
   input  logic                    i_rd_en,
   input  logic [CH_W-1:0]         i_rd_ch,
   output logic                    o_rd_valid,
   output logic [WIDTH-1:0]        o_rd_data,
   output logic [NUM_CH*WIDTH-1:0] o_values
);

   logic [WIDTH-1:0] regs     [NUM_CH];
   logic [WIDTH-1:0] defaults [NUM_CH];
   logic             idle;
   logic             sweep_en;
   logic [CH_W-1:0]  sweep_idx;
   logic             wr_fire;
   logic             wr_in_range;
   logic [WIDTH-1:0] rd_mux;

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      assign defaults[g]                  = WIDTH'(default_of(MAX_BITS'(DEFAULT_VAL), g, WIDTH));
      assign o_values[g*WIDTH +: WIDTH]   = regs[g];
   end

   default_regfile_sweep #(
      .NUM_CH (NUM_CH),
      .CH_W   (CH_W)
   ) u_sweep (
      .i_clk          (i_clk),
      .i_rst_n        (i_rst_n),
      .i_restore      (i_restore),
      .o_idle         (idle),
      .o_busy         (o_busy),
      .o_restore_done (o_restore_done),
      .o_sweep_en     (sweep_en),
      .o_sweep_idx    (sweep_idx)
   );

   assign o_wr_ready  = idle;
   assign wr_fire     = i_wr_valid && idle;
   assign wr_in_range = (32'(i_wr_ch) < NUM_CH);

`ifdef DEFAULT_REGFILE_PARITY_EN
   logic par_bits [NUM_CH];
   logic rd_par_mux;
`endif

   // Storage: writes only happen in IDLE and sweep loads only in SWEEP, so the
   // two never target the same cycle. Out-of-range write indices match no k.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int k = 0; k < NUM_CH; k++) begin
            regs[k] <= defaults[k];
`ifdef DEFAULT_REGFILE_PARITY_EN
            par_bits[k] <= even_par(MAX_W'(defaults[k]));
`endif
         end
         o_wr_err <= 1'b0;
      end else begin
         for (int k = 0; k < NUM_CH; k++) begin
            if (sweep_en && (sweep_idx == CH_W'(k))) begin
               regs[k] <= defaults[k];
`ifdef DEFAULT_REGFILE_PARITY_EN
               par_bits[k] <= even_par(MAX_W'(defaults[k]));
`endif
            end else if (wr_fire && (i_wr_ch == CH_W'(k))) begin
               regs[k] <= i_wr_data;
`ifdef DEFAULT_REGFILE_PARITY_EN
               par_bits[k] <= even_par(MAX_W'(i_wr_data)) ^ i_par_flip;
`endif
            end
         end
         o_wr_err <= wr_fire && !wr_in_range;
      end
   end

   // Read select; an index matching no channel yields zero.
   always_comb begin
      rd_mux = '0;
`ifdef DEFAULT_REGFILE_PARITY_EN
      rd_par_mux = 1'b0;
`endif
      for (int k = 0; k < NUM_CH; k++) begin
         if (i_rd_ch == CH_W'(k)) begin
            rd_mux = regs[k];
`ifdef DEFAULT_REGFILE_PARITY_EN
            rd_par_mux = even_par(MAX_W'(regs[k])) ^ par_bits[k];
`endif
         end
      end
   end

   // Read output stage: samples pre-write contents, data held while idle.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_rd_valid <= 1'b0;
         o_rd_data  <= '0;
`ifdef DEFAULT_REGFILE_PARITY_EN
         o_rd_par_err <= 1'b0;
`endif
      end else begin
         o_rd_valid <= i_rd_en;
         if (i_rd_en) begin
            o_rd_data <= rd_mux;
         end
`ifdef DEFAULT_REGFILE_PARITY_EN
         o_rd_par_err <= i_rd_en && rd_par_mux;
`endif
      end
   end

endmodule

// File: tb/tb_default_value_regfile.sv
// tb_default_value_regfile
//   Bench for default_value_regfile: instance A (4 x 8, defaults 44332211)
//   with a read scoreboard, instance B (3 x 8) for out-of-range handling.
//   Parity checks are compiled in with DEFAULT_REGFILE_PARITY_EN.
module tb_default_value_regfile;

   localparam logic [31:0] DEF_A = 32'h44332211;
   localparam logic [23:0] DEF_B = 24'h332211;

   logic        clk;
   logic        rst_n;

   logic        a_wr_valid, a_wr_ready, a_wr_err, a_restore, a_busy, a_done;
   logic [1:0]  a_wr_ch, a_rd_ch;
   logic [7:0]  a_wr_data, a_rd_data;
   logic        a_rd_en, a_rd_valid;
   logic [31:0] a_values;

   logic        b_wr_valid, b_wr_ready, b_wr_err, b_restore, b_busy, b_done;
   logic [1:0]  b_wr_ch, b_rd_ch;
   logic [7:0]  b_wr_data, b_rd_data;
   logic        b_rd_en, b_rd_valid;
   logic [23:0] b_values;

`ifdef DEFAULT_REGFILE_PARITY_EN
   logic        a_par_flip, a_rd_par_err, b_par_flip, b_rd_par_err;
`endif

   default_value_regfile #(.NUM_CH(4), .WIDTH(8), .DEFAULT_VAL(DEF_A)) u_dut_a (
      .i_clk          (clk),
      .i_rst_n        (rst_n),
`ifdef DEFAULT_REGFILE_PARITY_EN
      .i_par_flip     (a_par_flip),
      .o_rd_par_err   (a_rd_par_err),
`endif
      .i_wr_valid     (a_wr_valid),
      .o_wr_ready     (a_wr_ready),
      .i_wr_ch        (a_wr_ch),
      .i_wr_data      (a_wr_data),
      .o_wr_err       (a_wr_err),
      .i_restore      (a_restore),
      .o_busy         (a_busy),
      .o_restore_done (a_done),
      .i_rd_en        (a_rd_en),
      .i_rd_ch        (a_rd_ch),
      .o_rd_valid     (a_rd_valid),
      .o_rd_data      (a_rd_data),
      .o_values       (a_values)
   );

   default_value_regfile #(.NUM_CH(3), .WIDTH(8), .DEFAULT_VAL(DEF_B)) u_dut_b (
      .i_clk          (clk),
      .i_rst_n        (rst_n),
`ifdef DEFAULT_REGFILE_PARITY_EN
      .i_par_flip     (b_par_flip),
      .o_rd_par_err   (b_rd_par_err),
`endif
      .i_wr_valid     (b_wr_valid),
      .o_wr_ready     (b_wr_ready),
      .i_wr_ch        (b_wr_ch),
      .i_wr_data      (b_wr_data),
      .o_wr_err       (b_wr_err),
      .i_restore      (b_restore),
      .o_busy         (b_busy),
      .o_restore_done (b_done),
      .i_rd_en        (b_rd_en),
      .i_rd_ch        (b_rd_ch),
      .o_rd_valid     (b_rd_valid),
      .o_rd_data      (b_rd_data),
      .o_values       (b_values)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] want);
      n_chk++;
      if (got === want) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, want);
   endtask

   // Reference model of instance A and its read scoreboard.
   logic [7:0] model   [4];
   bit         par_bad [4];
   logic [7:0] q_rd  [$];
   bit         q_par [$];

   task automatic model_defaults();
      logic [31:0] d;
      d = DEF_A;
      for (int k = 0; k < 4; k++) begin
         model[k]   = d[k*8 +: 8];
         par_bad[k] = 1'b0;
      end
   endtask

   always @(negedge clk) begin
      logic [7:0] e_data;
      bit         e_par;
      if (a_rd_valid === 1'b1) begin
         if (q_rd.size() == 0) begin
            check_val("rd_unexpected", 64'(1), 64'(0));
         end else begin
            e_data = q_rd.pop_front();
            e_par  = q_par.pop_front();
            check_val("rd_data", 64'(a_rd_data), 64'(e_data));
`ifdef DEFAULT_REGFILE_PARITY_EN
            check_val("rd_par_err", 64'(a_rd_par_err), 64'(e_par));
`else
            e_par = 1'b0;
`endif
         end
      end
   end

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic a_read(input int ch);
      a_rd_en = 1'b1;
      a_rd_ch = ch[1:0];
      q_rd.push_back(model[ch]);
      q_par.push_back(par_bad[ch]);
      tick();
      a_rd_en = 1'b0;
   endtask

   task automatic a_write(input int ch, input logic [7:0] data, input bit flip);
      a_wr_valid = 1'b1;
      a_wr_ch    = ch[1:0];
      a_wr_data  = data;
`ifdef DEFAULT_REGFILE_PARITY_EN
      a_par_flip = flip;
`endif
      check_val("wr_ready", 64'(a_wr_ready), 64'(1));
      tick();
      a_wr_valid = 1'b0;
`ifdef DEFAULT_REGFILE_PARITY_EN
      a_par_flip = 1'b0;
`endif
      model[ch]   = data;
      par_bad[ch] = flip;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int busy_cnt, done_cnt, done_at;

      rst_n = 1'b0;
      a_wr_valid = 0; a_wr_ch = 0; a_wr_data = 0; a_restore = 0; a_rd_en = 0; a_rd_ch = 0;
      b_wr_valid = 0; b_wr_ch = 0; b_wr_data = 0; b_restore = 0; b_rd_en = 0; b_rd_ch = 0;
`ifdef DEFAULT_REGFILE_PARITY_EN
      a_par_flip = 0; b_par_flip = 0;
`endif
      model_defaults();
      repeat (2) tick();

      // Reset state
      check_val("rst_values_a", 64'(a_values), 64'(DEF_A));
      check_val("rst_values_b", 64'(b_values), 64'(DEF_B));
      check_val("rst_busy", 64'(a_busy), 64'(0));
      check_val("rst_done", 64'(a_done), 64'(0));
      check_val("rst_rd_valid", 64'(a_rd_valid), 64'(0));
      check_val("rst_rd_data", 64'(a_rd_data), 64'(0));
      check_val("rst_wr_err", 64'(a_wr_err), 64'(0));
      rst_n = 1'b1;
      tick();

      // Default readback of every channel
      for (int k = 0; k < 4; k++) a_read(k);
      tick();
      check_val("rd_data_hold", 64'(a_rd_data), 64'(8'h44));

      // Write ch2 with a same-cycle read of ch2 (must see the old value)
      a_wr_valid = 1'b1; a_wr_ch = 2'd2; a_wr_data = 8'hA5;
      a_rd_en = 1'b1; a_rd_ch = 2'd2;
      q_rd.push_back(model[2]);
      q_par.push_back(1'b0);
      check_val("wr_ready_idle", 64'(a_wr_ready), 64'(1));
      tick();
      a_wr_valid = 1'b0; a_rd_en = 1'b0;
      model[2] = 8'hA5;
      check_val("values_ch2", 64'(a_values[23:16]), 64'(8'hA5));
      check_val("wr_err_inrange", 64'(a_wr_err), 64'(0));
      a_read(2);
      tick();

      // Restore sweep after filling all channels with FF
      for (int k = 0; k < 4; k++) a_write(k, 8'hFF, 1'b0);
      check_val("values_ff", 64'(a_values), 64'(32'hFFFFFFFF));
      a_restore = 1'b1;
      tick();
      a_restore = 1'b0;
      busy_cnt = 0; done_cnt = 0; done_at = 0;
      for (int i = 1; i <= 8; i++) begin
         if (a_busy) begin
            busy_cnt++;
            check_val("ready_in_sweep", 64'(a_wr_ready), 64'(0));
         end
         if (a_done) begin
            done_cnt++;
            done_at = i;
         end
         if (i == 2) a_restore = 1'b1;
         if (i == 3) a_restore = 1'b0;
         tick();
      end
      check_val("sweep_busy_cycles", 64'(busy_cnt), 64'(4));
      check_val("sweep_done_count", 64'(done_cnt), 64'(1));
      check_val("sweep_done_cycle", 64'(done_at), 64'(5));
      check_val("sweep_values", 64'(a_values), 64'(DEF_A));
      check_val("ready_after_sweep", 64'(a_wr_ready), 64'(1));
      model_defaults();
      for (int k = 0; k < 4; k++) a_read(k);
      tick();

      // Reset in the middle of a sweep
      a_write(3, 8'h5A, 1'b0);
      a_restore = 1'b1;
      tick();
      a_restore = 1'b0;
      tick();
      rst_n = 1'b0;
      #1;
      check_val("midrst_values", 64'(a_values), 64'(DEF_A));
      check_val("midrst_busy", 64'(a_busy), 64'(0));
      done_cnt = 0;
      for (int i = 0; i < 3; i++) begin
         tick();
         if (a_done) done_cnt++;
      end
      rst_n = 1'b1;
      tick();
      check_val("midrst_ready", 64'(a_wr_ready), 64'(1));
      for (int i = 0; i < 6; i++) begin
         if (a_done) done_cnt++;
         tick();
      end
      check_val("midrst_no_done", 64'(done_cnt), 64'(0));
      model_defaults();
      a_read(3);
      tick();

      // Out-of-range write and read on the 3-channel instance
      b_wr_valid = 1'b1; b_wr_ch = 2'd3; b_wr_data = 8'h77;
      check_val("b_wr_ready", 64'(b_wr_ready), 64'(1));
      tick();
      b_wr_valid = 1'b0;
      check_val("b_wr_err_pulse", 64'(b_wr_err), 64'(1));
      check_val("b_values_kept", 64'(b_values), 64'(DEF_B));
      tick();
      check_val("b_wr_err_clear", 64'(b_wr_err), 64'(0));
      b_rd_en = 1'b1; b_rd_ch = 2'd3;
      tick();
      b_rd_en = 1'b0;
      check_val("b_oor_rd_valid", 64'(b_rd_valid), 64'(1));
      check_val("b_oor_rd_data", 64'(b_rd_data), 64'(0));
`ifdef DEFAULT_REGFILE_PARITY_EN
      check_val("b_oor_par_err", 64'(b_rd_par_err), 64'(0));
`endif
      b_rd_en = 1'b1; b_rd_ch = 2'd2;
      tick();
      b_rd_en = 1'b0;
      check_val("b_rd_ch2", 64'(b_rd_data), 64'(8'h33));
      tick();
      check_val("b_rd_valid_low", 64'(b_rd_valid), 64'(0));

`ifdef DEFAULT_REGFILE_PARITY_EN
      // Parity error injection and clearing on channel 1
      a_write(1, 8'h03, 1'b1);
      a_read(1);
      a_write(1, 8'h03, 1'b0);
      a_read(1);
      tick();
`endif

      repeat (2) tick();
      check_val("scoreboard_drain", 64'(q_rd.size()), 64'(0));

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
